// File: rtl/alu_execute_stage.sv
// Execute-stage front end: single-cycle ALU ops, div/mod sequencing through the divider handshake, E/GT flags.
// Latency: single-cycle ops 1 cycle; div/mod 1 cycle after the divider drops busy (minimum 5 cycles).
// Backpressure: stall_out holds the OF/EX latch during hold_in, a div/mod issue or block, and while the divider is busy.
module alu_execute_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hold_in,
  output logic             stall_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic             flag_e,
  output logic             flag_gt,
  output logic             div_req,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  input  logic             div_busy,
  input  logic [31:0]      div_quo,
  input  logic [31:0]      div_rem
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_LSL = 4'd10;
  localparam logic [3:0] OP_LSR = 4'd11;
  localparam logic [3:0] OP_ASR = 4'd12;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_DIV_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             flag_e_q, flag_e_d;
  logic             flag_gt_q, flag_gt_d;
  logic [31:0]      div_a_q, div_a_d;
  logic [31:0]      div_b_q, div_b_d;
  logic             op_mod_q, op_mod_d;
  // One-entry skid: a divider result that lands while hold_in is high waits here.
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;

  logic             is_divmod;
  logic             b_zero;
  logic             idle_take;
  logic             div_needed;
  logic             div_issue;
  logic             single_take;
  logic             div_done;
  logic             alu_vld;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] div_res;
  logic [4:0]       shamt;
  logic [31:0]      a32;
  logic [31:0]      b32;

  assign is_divmod = (alu_op == OP_DIV) || (alu_op == OP_MOD);
  assign b_zero    = (op_b == '0);
  assign shamt     = op_b[4:0];
  assign a32       = 32'(op_a);
  assign b32       = 32'(op_b);

  // The skid entry blocks acceptance: in its drain cycle the latch still holds the
  // finished div/mod, which is retired (stall_out low) without being re-issued.
  assign idle_take   = (state_q == S_IDLE) && !skid_vld_q && in_valid && !hold_in;
  assign div_needed  = is_divmod && !b_zero;
  assign div_issue   = idle_take && div_needed && !div_busy;
  assign single_take = idle_take && !div_needed;
  assign div_done    = (state_q == S_DIV_WAIT) && !div_busy;
  assign div_res     = WIDTH'(op_mod_q ? div_rem : div_quo);

  assign div_req   = div_issue && !rst;
  assign stall_out = hold_in
                   || ((state_q == S_IDLE) && !skid_vld_q && in_valid && div_needed)
                   || ((state_q == S_DIV_WAIT) && div_busy);

  // Operands go to the divider straight from the latch in the request cycle and from
  // the capture registers afterwards, so A/B stay stable from request to result.
  assign div_a = div_req ? a32 : div_a_q;
  assign div_b = div_req ? b32 : div_b_q;

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign flag_e     = flag_e_q;
  assign flag_gt    = flag_gt_q;

  // Single-cycle function unit; div/mod here only cover the divide-by-zero shortcut.
  always_comb begin
    alu_vld = 1'b1;
    alu_res = '0;
    case (alu_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_MUL:  alu_res = op_a * op_b;
      OP_DIV:  alu_res = '1;
      OP_MOD:  alu_res = op_a;
      OP_CMP:  alu_res = '0;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_NOT:  alu_res = ~op_b;
      OP_MOV:  alu_res = op_b;
      OP_LSL:  alu_res = op_a << shamt;
      OP_LSR:  alu_res = op_a >> shamt;
      OP_ASR:  alu_res = $unsigned($signed(op_a) >>> shamt);
      default: alu_vld = 1'b0;
    endcase
  end

  // Next-state: result selection priority is skid drain, divider completion, new instruction.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    flag_e_d     = flag_e_q;
    flag_gt_d    = flag_gt_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    op_mod_d     = op_mod_q;
    skid_vld_d   = skid_vld_q;
    skid_dat_d   = skid_dat_q;
    if (!hold_in) begin
      out_valid_d = 1'b0;
      if (skid_vld_q) begin
        out_valid_d  = 1'b1;
        out_result_d = skid_dat_q;
        skid_vld_d   = 1'b0;
      end else if (div_done) begin
        out_valid_d  = 1'b1;
        out_result_d = div_res;
        state_d      = S_IDLE;
      end else if (div_issue) begin
        state_d  = S_DIV_WAIT;
        op_mod_d = (alu_op == OP_MOD);
        div_a_d  = a32;
        div_b_d  = b32;
      end else if (single_take) begin
        out_valid_d = alu_vld;
        if (alu_vld) begin
          out_result_d = alu_res;
        end
        if (alu_op == OP_CMP) begin
          flag_e_d  = (op_a == op_b);
          flag_gt_d = ($signed(op_a) > $signed(op_b));
        end
      end
    end else if (div_done) begin
      skid_vld_d = 1'b1;
      skid_dat_d = div_res;
      state_d    = S_IDLE;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      flag_e_q     <= 1'b0;
      flag_gt_q    <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      op_mod_q     <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_dat_q   <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      flag_e_q     <= flag_e_d;
      flag_gt_q    <= flag_gt_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      op_mod_q     <= op_mod_d;
      skid_vld_q   <= skid_vld_d;
      skid_dat_q   <= skid_dat_d;
    end
  end

endmodule
